result_frame_tx: RTL

Serializes one 32-bit result word onto the UART line as four 8N1 bytes, least-significant byte first. It is the transmit-side counterpart of the receive path that assembles 32-bit input words from four UART bytes in the same byte order. It sits between the network output stage and the `RsTx` pin. It replaces the single-byte send with a framed, handshaked word transmitter that reports completion.

---
 rtl/uart_frame_pkg.sv | 14 +
 rtl/uart_byte_tx.sv | 102 ++++++++++
 rtl/result_frame_tx.sv | 72 +++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART word transmit and receive paths.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int BITS_PER_BYTE        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 byte on the line: start bit, eight data bits LSB first, stop bit.
// A load in the last stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [BITS_PER_BYTE-1:0] byte_in,
    output logic                     byte_done,
    output logic                     tx
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(BITS_PER_BYTE - 1);

    uart_state_e              state, state_nxt;
    logic [CNT_W-1:0]         baud_cnt, baud_cnt_nxt;
    logic [2:0]               bit_idx, bit_idx_nxt;
    logic [BITS_PER_BYTE-1:0] shreg, shreg_nxt;
    logic                     tx_q, tx_nxt;
    logic                     bit_end;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign byte_done = (state == STOP) && bit_end;
    assign tx        = tx_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_nxt    = state;
        baud_cnt_nxt = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        tx_nxt       = tx_q;

        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = START;
                    shreg_nxt = byte_in;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                    tx_nxt      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        shreg_nxt   = shreg >> 1;
                        tx_nxt      = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (load) begin
                        state_nxt = START;
                        shreg_nxt = byte_in;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            tx_q     <= tx_nxt;
        end
    end

endmodule

// File: rtl/result_frame_tx.sv
// Sends a WORD_W-bit result as WORD_W/8 back-to-back 8N1 bytes, LSB byte first,
// with a busy flag and a one-cycle done pulse after the last stop bit.
module result_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORD_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              tx
);

    localparam int               NBYTES   = WORD_W / BITS_PER_BYTE;
    localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    logic                     busy_q, done_q;
    logic [IDX_W-1:0]         byte_idx;
    logic [WORD_W-1:0]        word_sr;
    logic                     accept, next_byte, load, byte_done;
    logic [BITS_PER_BYTE-1:0] byte_in;

    // word_sr holds the bytes still waiting behind the one on the line.
    assign accept    = start && !busy_q;
    assign next_byte = byte_done && (byte_idx != IDX_LAST);
    assign load      = accept || next_byte;
    assign byte_in   = accept ? data[BITS_PER_BYTE-1:0] : word_sr[BITS_PER_BYTE-1:0];

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .byte_in  (byte_in),
        .byte_done(byte_done),
        .tx       (tx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            byte_idx <= '0;
            word_sr  <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q   <= 1'b1;
                byte_idx <= '0;
                word_sr  <= data >> BITS_PER_BYTE;
            end else if (byte_done) begin
                if (next_byte) begin
                    byte_idx <= byte_idx + 1'b1;
                    word_sr  <= word_sr >> BITS_PER_BYTE;
                end else begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
